// File: rtl/float_adder_pipe.sv
// Three-stage pipelined adder for small sign/exponent/fraction floats.
// Operands with a zero exponent field are treated as signed zero, and an
// all-ones exponent is an ordinary finite value (no inf/NaN encodings).
// S1 unpacks and aligns the operands, S2 adds or subtracts the magnitudes,
// and S3 normalises, rounds to nearest-even, saturates or flushes, and packs.
module float_adder_pipe #(
   parameter int EXP_W = 4,
   parameter int MAN_W = 3,
   parameter int BIAS  = 2**(EXP_W-1)-1,
   localparam int W    = 1 + EXP_W + MAN_W
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] y
);

   localparam int SW  = MAN_W + 1;   // significand including hidden bit
   localparam int AW  = SW + 3;      // significand plus guard/round/sticky
   localparam int SHW = SW + 2;      // significand plus guard/round, before sticky
   localparam int XW  = EXP_W + 2;   // signed unbiased exponent width

   // Unbiased exponent range that still packs into a finite normal result.
   localparam logic signed [XW-1:0] LP_EMAX = XW'((2**EXP_W) - 1 - BIAS);
   localparam logic signed [XW-1:0] LP_EMIN = XW'(1 - BIAS);

   logic                 w_adv;

   logic                 r1_valid, r1_sign, r1_sub, r1_zsign;
   logic signed [XW-1:0] r1_exp;
   logic [AW-1:0]        r1_big, r1_small;

   logic                 r2_valid, r2_sign, r2_zsign;
   logic signed [XW-1:0] r2_exp;
   logic [AW:0]          r2_sum;

   logic                 r3_valid;
   logic [W-1:0]         r3_y;

   logic [EXP_W-1:0]     w_ea, w_eb, w_bg_e, w_sm_e, w_diff;
   logic [MAN_W-1:0]     w_fa, w_fb;
   logic                 w_a_big, w_bg_s, w_sm_s;
   logic [SW-1:0]        w_bg_sig, w_sm_sig;
   int                   w_shamt;
   logic [2*SHW-1:0]     w_sh_full;
   logic [AW-1:0]        w_sm_al;

   int                   w_lzc;
   logic                 w_found;
   logic [AW-1:0]        w_norm;
   logic signed [XW-1:0] w_exp_n, w_exp_r;
   logic [EXP_W-1:0]     w_exp_f;
   logic [SW-1:0]        w_sig;
   logic                 w_rnd;
   logic [SW:0]          w_sig_r;
   logic [MAN_W-1:0]     w_frac;
   logic [W-1:0]         w_y;

   assign w_adv     = !r3_valid || out_ready;
   assign in_ready  = w_adv;
   assign out_valid = r3_valid;
   assign y         = r3_y;

   // S1 combinational: flush zero operands, pick the larger magnitude as base,
   // and right-align the smaller one, collecting shifted-out bits into sticky.
   always_comb begin
      w_ea = a[W-2:MAN_W];
      w_eb = b[W-2:MAN_W];
      w_fa = (w_ea == '0) ? '0 : a[MAN_W-1:0];
      w_fb = (w_eb == '0) ? '0 : b[MAN_W-1:0];
      w_a_big = {w_ea, w_fa} >= {w_eb, w_fb};
      if (w_a_big) begin
         w_bg_s   = a[W-1];
         w_bg_e   = w_ea;
         w_bg_sig = {(w_ea != '0), w_fa};
         w_sm_s   = b[W-1];
         w_sm_e   = w_eb;
         w_sm_sig = {(w_eb != '0), w_fb};
      end else begin
         w_bg_s   = b[W-1];
         w_bg_e   = w_eb;
         w_bg_sig = {(w_eb != '0), w_fb};
         w_sm_s   = a[W-1];
         w_sm_e   = w_ea;
         w_sm_sig = {(w_ea != '0), w_fa};
      end
      w_diff = w_bg_e - w_sm_e;
      // Any shift past the round bit leaves the whole operand in sticky.
      w_shamt   = (int'(w_diff) > SHW) ? SHW : int'(w_diff);
      w_sh_full = {w_sm_sig, 2'b00, {SHW{1'b0}}} >> w_shamt;
      w_sm_al   = {w_sh_full[2*SHW-1:SHW], |w_sh_full[SHW-1:0]};
   end

   // S1 registers: ordered, aligned operands; the sign pair is kept for a zero sum.
   always_ff @(posedge clock) begin
      if (reset) begin
         r1_valid <= 1'b0;
         r1_sign  <= 1'b0;
         r1_sub   <= 1'b0;
         r1_zsign <= 1'b0;
         r1_exp   <= '0;
         r1_big   <= '0;
         r1_small <= '0;
      end else if (w_adv) begin
         r1_valid <= in_valid;
         r1_sign  <= w_bg_s;
         r1_sub   <= w_bg_s ^ w_sm_s;
         r1_zsign <= a[W-1] & b[W-1];
         r1_exp   <= $signed({2'b00, w_bg_e}) - XW'(BIAS);
         r1_big   <= {w_bg_sig, 3'b000};
         r1_small <= w_sm_al;
      end
   end

   // S2 registers: magnitude add or subtract with one carry bit.
   always_ff @(posedge clock) begin
      if (reset) begin
         r2_valid <= 1'b0;
         r2_sign  <= 1'b0;
         r2_zsign <= 1'b0;
         r2_exp   <= '0;
         r2_sum   <= '0;
      end else if (w_adv) begin
         r2_valid <= r1_valid;
         r2_sign  <= r1_sign;
         r2_zsign <= r1_zsign;
         r2_exp   <= r1_exp;
         r2_sum   <= r1_sub ? ({1'b0, r1_big} - {1'b0, r1_small})
                            : ({1'b0, r1_big} + {1'b0, r1_small});
      end
   end

   // S3 combinational: normalise, round to nearest-even, then saturate/flush and pack.
   always_comb begin
      w_lzc   = 0;
      w_found = 1'b0;
      for (int i = AW-1; i >= 0; i--) begin
         if (!w_found) begin
            if (r2_sum[i]) w_found = 1'b1;
            else           w_lzc   = w_lzc + 1;
         end
      end
      if (r2_sum[AW]) begin
         w_norm  = {r2_sum[AW:2], r2_sum[1] | r2_sum[0]};
         w_exp_n = r2_exp + XW'(1);
      end else begin
         w_norm  = r2_sum[AW-1:0] << w_lzc;
         w_exp_n = r2_exp - XW'(w_lzc);
      end
      w_sig   = w_norm[AW-1:3];
      w_rnd   = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
      w_sig_r = {1'b0, w_sig} + (SW+1)'(w_rnd);
      if (w_sig_r[SW]) begin
         w_frac  = w_sig_r[MAN_W:1];
         w_exp_r = w_exp_n + XW'(1);
      end else begin
         w_frac  = w_sig_r[MAN_W-1:0];
         w_exp_r = w_exp_n;
      end
      w_exp_f = w_exp_r[EXP_W-1:0] + EXP_W'(BIAS);
      // A zero sum is +0 on cancellation and keeps the sign only for (-0)+(-0).
      if (r2_sum == '0)
         w_y = {r2_zsign, {(W-1){1'b0}}};
      else if (w_exp_r > LP_EMAX)
         w_y = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
      else if (w_exp_r < LP_EMIN)
         w_y = {r2_sign, {(W-1){1'b0}}};
      else
         w_y = {r2_sign, w_exp_f, w_frac};
   end

   // S3 registers: output stage, held while the consumer stalls.
   always_ff @(posedge clock) begin
      if (reset) begin
         r3_valid <= 1'b0;
         r3_y     <= '0;
      end else if (w_adv) begin
         r3_valid <= r2_valid;
         r3_y     <= w_y;
      end
   end

endmodule

// File: tb/tb_float_adder_pipe.sv
// Bench for float_adder_pipe (E4M3 defaults): directed vectors, back-pressure,
// reset mid-flight and random operands against a real-arithmetic reference.
module tb_float_adder_pipe;

   logic       clock = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] y;

   int         total = 0;
   int         bad   = 0;
   int         n_out = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_e;

   float_adder_pipe dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y)
   );

   always #5 clock = ~clock;

   function automatic real pow2(input int n);
      real r = 1.0;
      if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
      else        for (int i = 0; i < -n; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic real dec(input logic [7:0] x);
      real v;
      if (x[6:3] == 4'd0) return 0.0;
      v = (1.0 + real'(x[2:0]) / 8.0) * pow2(int'(x[6:3]) - 7);
      return x[7] ? -v : v;
   endfunction

   // Exact real sum, rounded to nearest-even with an unbounded exponent,
   // then saturated or flushed to the E4M3 normal range.
   function automatic logic [7:0] ref_add(input logic [7:0] xa, input logic [7:0] xb);
      real s, m, q, fl;
      int  e, qi;
      logic sg;
      s = dec(xa) + dec(xb);
      if (s == 0.0) begin
         if (xa[6:3] == 4'd0 && xb[6:3] == 4'd0) return {xa[7] & xb[7], 7'd0};
         return 8'h00;
      end
      sg = (s < 0.0);
      m  = sg ? -s : s;
      e  = 0;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0)  begin m = m * 2.0; e--; end
      q  = m * 8.0;
      fl = $floor(q);
      qi = $rtoi(fl);
      if ((q - fl > 0.5) || ((q - fl == 0.5) && (qi % 2 == 1))) qi++;
      if (qi == 16) begin qi = 8; e++; end
      if (e + 7 > 15) return {sg, 7'h7F};
      if (e + 7 < 1)  return {sg, 7'h00};
      return {sg, 4'(e + 7), 3'(qi - 8)};
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, obs, expv);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the handshake edge.
   task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] te);
      int   waited = 0;
      logic acc    = 1'b0;
      a = ta;
      b = tb;
      in_valid = 1'b1;
      while (!acc && waited < 20) begin
         @(negedge clock);
         acc = in_ready;
         @(posedge clock);
         #1;
         waited++;
      end
      chk("send_accept", {7'd0, acc}, 8'd1);
      if (acc) exp_q.push_back(te);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      a = 8'h00;
      b = 8'h00;
   endtask

   task automatic drain();
      int w = 0;
      while (exp_q.size() != 0 && w < 50) begin
         @(posedge clock);
         w++;
      end
      #1;
      chk("drain_empty", 8'(exp_q.size()), 8'd0);
   endtask

   task automatic latency_check(input string tag);
      @(negedge clock);
      chk({tag, "_c1"}, {7'd0, out_valid}, 8'd0);
      @(negedge clock);
      chk({tag, "_c2"}, {7'd0, out_valid}, 8'd0);
      @(negedge clock);
      chk({tag, "_c3"}, {7'd0, out_valid}, 8'd1);
      @(posedge clock);
      #1;
   endtask

   // Scoreboard: every transfer pops the oldest expectation.
   always @(negedge clock) begin
      if (!reset && out_valid && out_ready) begin
         n_out++;
         total++;
         assert (exp_q.size() > 0) else begin
            bad++;
            $error("FAIL out_unexpected got=%h exp=none", y);
         end
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            total++;
            assert (y === mon_e) else begin
               bad++;
               $error("FAIL out_y got=%h exp=%h", y, mon_e);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [23:0] dvec[$];
      logic [23:0] v;
      logic [7:0]  ra, rb;
      int          nb;

      reset     = 1'b1;
      in_valid  = 1'b0;
      a         = 8'h00;
      b         = 8'h00;
      out_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
      chk("rst_y", y, 8'h00);
      chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
      @(posedge clock);
      #1;

      // 1.0 + 1.0 with latency measured from the acceptance cycle
      send(8'h38, 8'h38, 8'h40);
      idle();
      latency_check("lat");
      drain();

      // directed vectors {a, b, expected}
      dvec = '{24'h3CB830, 24'h38B800, 24'h381838, 24'h39183A, 24'h7F7F7F,
               24'h3F1840, 24'h7F587F, 24'h3F3F47, 24'h808080, 24'h008000,
               24'h458045, 24'h05C3C3, 24'h098800, 24'h890880, 24'h700870,
               24'h40A93E};
      foreach (dvec[i]) begin
         v = dvec[i];
         send(v[23:16], v[15:8], v[7:0]);
      end
      idle();
      drain();

      // back-pressure: stall the consumer for 4 cycles with a full pipeline
      nb = n_out;
      out_ready = 1'b0;
      send(8'h38, 8'h38, 8'h40);
      send(8'h3C, 8'hB8, 8'h30);
      send(8'h39, 8'h18, 8'h3A);
      a = 8'h45;
      b = 8'h80;
      in_valid = 1'b1;
      repeat (4) begin
         @(negedge clock);
         chk("bp_in_ready", {7'd0, in_ready}, 8'd0);
         chk("bp_out_valid", {7'd0, out_valid}, 8'd1);
         chk("bp_y_hold", y, 8'h40);
         @(posedge clock);
         #1;
      end
      out_ready = 1'b1;
      send(8'h45, 8'h80, 8'h45);
      send(8'h3F, 8'h3F, 8'h47);
      idle();
      drain();
      chk("bp_count", 8'(n_out - nb), 8'd5);

      // reset with three operations in flight
      out_ready = 1'b0;
      send(8'h38, 8'h38, 8'h40);
      send(8'h3F, 8'h18, 8'h40);
      send(8'h7F, 8'h7F, 8'h7F);
      idle();
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      exp_q.delete();
      @(negedge clock);
      chk("mid_rst_out_valid", {7'd0, out_valid}, 8'd0);
      chk("mid_rst_y", y, 8'h00);
      chk("mid_rst_in_ready", {7'd0, in_ready}, 8'd1);
      @(posedge clock);
      #1;
      out_ready = 1'b1;
      send(8'h3C, 8'hB8, 8'h30);
      idle();
      latency_check("post_rst_lat");
      drain();

      // random operands with occasional bubble/stall cycles
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            idle();
            out_ready = 1'b0;
            @(posedge clock);
            #1;
            out_ready = 1'b1;
         end
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         send(ra, rb, ref_add(ra, rb));
      end
      idle();
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
